// File: rtl/move_scan_encoder.sv
// Keyboard emulator: queues key press/release events and emits the matching
// scan-code byte stream (release = F0 then code), paced by a fixed idle gap.
module move_scan_encoder #(
    parameter int GAP_CYCLES = 4,
    parameter int QDEPTH     = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       key_valid,
    input  logic [2:0] key_id,
    input  logic       key_release,
    output logic [7:0] data,
    output logic       data_en,
    output logic       Ready,
    output logic       Overflow,
    output logic       Error
);
    localparam int CNT_W = $clog2(GAP_CYCLES + 1);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int QCNT_W = $clog2(QDEPTH + 1);

    typedef enum logic {IDLE, GAP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              pend, pend_n;
    logic [7:0]        code, code_n;
    logic [7:0]        data_n;
    logic              data_en_n;

    logic [3:0]        q_mem [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [QCNT_W-1:0] q_count;
    logic [3:0]        head;
    logic              id_ok, q_full, pop, push;

    function automatic logic [7:0] scan_code(input logic [2:0] id);
        case (id)
            3'd0:    scan_code = 8'h1D;
            3'd1:    scan_code = 8'h1B;
            3'd2:    scan_code = 8'h1C;
            3'd3:    scan_code = 8'h23;
            3'd4:    scan_code = 8'h35;
            default: scan_code = 8'h00;
        endcase
    endfunction

    assign id_ok  = (key_id <= 3'd4);
    assign q_full = (q_count == QCNT_W'(QDEPTH));
    assign Ready  = !q_full;
    assign head   = q_mem[rd_ptr];
    // Pop happens before push, so a full queue still accepts an event on a pop cycle.
    assign pop    = (state == IDLE) && (q_count != '0);
    assign push   = key_valid && id_ok && (!q_full || pop);

    always_ff @(posedge Clock) begin
        if (push) q_mem[wr_ptr] <= {key_release, key_id};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            q_count  <= '0;
            Overflow <= 1'b0;
            Error    <= 1'b0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            Overflow <= key_valid && id_ok && q_full && !pop;
            Error    <= key_valid && !id_ok;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= 1'b0;
            code    <= 8'h00;
            data    <= 8'h00;
            data_en <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            code    <= code_n;
            data    <= data_n;
            data_en <= data_en_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_n    = pend;
        code_n    = code;
        data_n    = data;
        data_en_n = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    data_n    = head[3] ? 8'hF0 : scan_code(head[2:0]);
                    data_en_n = 1'b1;
                    pend_n    = head[3];
                    code_n    = scan_code(head[2:0]);
                    cnt_n     = CNT_W'(GAP_CYCLES);
                    state_n   = GAP;
                end
            end
            GAP: begin
                // The strobe cycle itself is not an idle cycle; counting starts after it.
                if (!data_en) begin
                    if (cnt == CNT_W'(1)) begin
                        if (pend) begin
                            data_n    = code;
                            data_en_n = 1'b1;
                            pend_n    = 1'b0;
                            cnt_n     = CNT_W'(GAP_CYCLES);
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_move_scan_encoder.sv
// Directed bench for move_scan_encoder: expected bytes and their cycles are queued
// when events are driven and matched against each data_en strobe.
module tb_move_scan_encoder;
    localparam int GAP = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [2:0] key_id = 3'd0;
    logic       key_release = 1'b0;
    logic [7:0] data;
    logic       data_en;
    logic       Ready;
    logic       Overflow;
    logic       Error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic [7:0] b;
    } exp_t;
    exp_t sb[$];

    move_scan_encoder #(.GAP_CYCLES(GAP), .QDEPTH(4)) dut (
        .Clock(Clock), .Reset(Reset), .key_valid(key_valid), .key_id(key_id),
        .key_release(key_release), .data(data), .data_en(data_en), .Ready(Ready),
        .Overflow(Overflow), .Error(Error)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] id, input logic rel);
        @(posedge Clock);
        #1;
        key_valid   = v;
        key_id      = id;
        key_release = rel;
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0);
    endtask

    task automatic expect_byte(input int at, input logic [7:0] b);
        exp_t e;
        e.at = at;
        e.b  = b;
        sb.push_back(e);
    endtask

    always @(negedge Clock) begin
        if (!Reset && data_en === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_byte got %0h at cycle %0d expected none", data, cyc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("byte_value", {24'd0, data}, {24'd0, e.b});
                chk("byte_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int c0;
        logic [7:0] codes [5];
        codes[0] = 8'h1D; codes[1] = 8'h1B; codes[2] = 8'h1C;
        codes[3] = 8'h23; codes[4] = 8'h35;

        // Reset state
        @(negedge Clock);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_data_en", {31'd0, data_en}, 32'd0);
        chk("rst_ready", {31'd0, Ready}, 32'd1);
        chk("rst_overflow", {31'd0, Overflow}, 32'd0);
        chk("rst_error", {31'd0, Error}, 32'd0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        idle(2);

        // Single press UP
        step(1'b1, 3'd0, 1'b0);
        c0 = cyc;
        expect_byte(c0 + 2, 8'h1D);
        idle(20);
        chk("t1_drained", sb.size(), 0);

        // Release RIGHT: F0 then 23
        step(1'b1, 3'd3, 1'b1);
        c0 = cyc;
        expect_byte(c0 + 2, 8'hF0);
        expect_byte(c0 + 3 + GAP, 8'h23);
        idle(25);
        chk("t2_drained", sb.size(), 0);

        // Six presses into a 4-deep queue: sixth is dropped
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 3'(k % 5), 1'b0);
            if (k == 0) c0 = cyc;
            if (k < 5) expect_byte(c0 + 2 + k * (GAP + 2), codes[k]);
            if (k == 4) chk("t3_ready_c4", {31'd0, Ready}, 32'd1);
            if (k == 5) begin
                chk("t3_ready_c5", {31'd0, Ready}, 32'd0);
                chk("t3_ovf_c5", {31'd0, Overflow}, 32'd0);
            end
        end
        idle(1);
        chk("t3_ovf_c6", {31'd0, Overflow}, 32'd1);
        idle(1);
        chk("t3_ovf_c7", {31'd0, Overflow}, 32'd0);
        idle(40);
        chk("t3_drained", sb.size(), 0);
        chk("t3_ready_end", {31'd0, Ready}, 32'd1);

        // Invalid key id
        step(1'b1, 3'd6, 1'b0);
        chk("t4_err_c0", {31'd0, Error}, 32'd0);
        idle(1);
        chk("t4_err_c1", {31'd0, Error}, 32'd1);
        chk("t4_ready_c1", {31'd0, Ready}, 32'd1);
        chk("t4_ovf_c1", {31'd0, Overflow}, 32'd0);
        idle(1);
        chk("t4_err_c2", {31'd0, Error}, 32'd0);
        idle(20);

        // Reset in the middle of a break sequence
        step(1'b1, 3'd1, 1'b1);
        c0 = cyc;
        expect_byte(c0 + 2, 8'hF0);
        idle(3);
        @(posedge Clock);
        #1 Reset = 1'b1;
        #1;
        chk("t5_rst_data", {24'd0, data}, 32'h00);
        chk("t5_rst_data_en", {31'd0, data_en}, 32'd0);
        chk("t5_rst_ready", {31'd0, Ready}, 32'd1);
        @(posedge Clock);
        #1 Reset = 1'b0;
        idle(15);
        chk("t5_no_code", sb.size(), 0);
        step(1'b1, 3'd1, 1'b0);
        c0 = cyc;
        expect_byte(c0 + 2, 8'h1B);
        idle(20);
        chk("t5_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
